// File: rtl/counter_chain_pkg.sv
// Shared defaults, packing helper and halt-state type for the cascaded counter chain.
package counter_chain_pkg;

    localparam int unsigned DEF_NUM_STAGES = 3;
    localparam int unsigned DEF_STAGE_W    = 4;

    // Upper bounds for the packing helper; chains wider than this need these raised.
    localparam int unsigned MAX_VEC_W   = 256;
    localparam int unsigned MAX_STAGE_W = 32;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } halt_state_e;

    // Returns stage idx of a packed vector in the low bits; the caller narrows to its width.
    function automatic logic [MAX_STAGE_W-1:0] stage_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [MAX_VEC_W-1:0] shifted;
        shifted = vec >> (idx * width);
        return shifted[MAX_STAGE_W-1:0];
    endfunction

endpackage

// File: rtl/cascaded_counter_chain_stage.sv
// One stage of the counter chain: counts on step_in, wraps to zero at or above its terminal.
module counter_stage
    import counter_chain_pkg::*;
#(
    parameter int unsigned STAGE_W = DEF_STAGE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               ld,
    input  logic               step_in,
    input  logic [STAGE_W-1:0] term,
    input  logic [STAGE_W-1:0] ld_val,
    output logic [STAGE_W-1:0] cnt,
    output logic               at_term,
    output logic               wrap
);

    logic [STAGE_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;

    // A loaded value above term is treated as terminal so the stage cannot run away.
    assign at_term = (cnt_q >= term);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (step_in) begin
            if (at_term) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + STAGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/cascaded_counter_chain.sv
// Chain of ripple-enabled counter stages with one-shot halt, parallel load and done pulse.
module cascaded_counter_chain
    import counter_chain_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned STAGE_W    = DEF_STAGE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          oneshot,
    input  logic                          ld,
    input  logic [NUM_STAGES*STAGE_W-1:0] ld_val,
    input  logic [NUM_STAGES*STAGE_W-1:0] term,
    output logic [NUM_STAGES*STAGE_W-1:0] count_o,
    output logic [NUM_STAGES-1:0]         wrap_o,
    output logic                          done_o,
    output logic                          busy_o
);

    logic [MAX_VEC_W-1:0]  ld_ext;
    logic [MAX_VEC_W-1:0]  term_ext;
    logic [NUM_STAGES-1:0] step;
    logic [NUM_STAGES-1:0] at_term;
    logic                  chain_wrap;
    logic                  done_q, done_d;
    halt_state_e           state_q, state_d;

    assign ld_ext   = MAX_VEC_W'(ld_val);
    assign term_ext = MAX_VEC_W'(term);

    assign step[0] = en && (state_q == StRun);

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic [STAGE_W-1:0] stage_term;
        logic [STAGE_W-1:0] stage_ld_val;
        logic [STAGE_W-1:0] stage_cnt;

        assign stage_term   = STAGE_W'(stage_slice(term_ext, i, STAGE_W));
        assign stage_ld_val = STAGE_W'(stage_slice(ld_ext, i, STAGE_W));

        if (i > 0) begin : g_carry
            assign step[i] = step[i-1] && at_term[i-1];
        end

        counter_stage #(
            .STAGE_W (STAGE_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .ld      (ld),
            .step_in (step[i]),
            .term    (stage_term),
            .ld_val  (stage_ld_val),
            .cnt     (stage_cnt),
            .at_term (at_term[i]),
            .wrap    (wrap_o[i])
        );

        assign count_o[i*STAGE_W +: STAGE_W] = stage_cnt;
    end

    // A step reaching the top stage at terminal means every lower stage wrapped this cycle.
    assign chain_wrap = step[NUM_STAGES-1] && at_term[NUM_STAGES-1];

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clr || ld) begin
            state_d = StRun;
        end else begin
            done_d = chain_wrap;
            if (chain_wrap && oneshot) begin
                state_d = StHalt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
    assign busy_o = (state_q == StRun);

endmodule

// File: tb/tb_cascaded_counter_chain.sv
// Self-checking bench: reference model feeds a scoreboard queue, DUT outputs are popped and compared.
module tb_cascaded_counter_chain;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 4;
    localparam int unsigned VW = N * W;

    logic          clk = 1'b0;
    logic          rst, clr, en, oneshot, ld;
    logic [VW-1:0] ld_val, term;
    logic [VW-1:0] count_o;
    logic [N-1:0]  wrap_o;
    logic          done_o, busy_o;

    // Sweep instances: 1x1 and 5x8.
    logic          en_p;
    logic [0:0]    term_a, ldv_a, cnt_a;
    logic [0:0]    wrap_a;
    logic          done_a, busy_a;
    logic [39:0]   term_b, ldv_b, cnt_b;
    logic [4:0]    wrap_b;
    logic          done_b, busy_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [VW-1:0] cnt;
        logic [N-1:0]  wrap;
        logic          done;
        logic          busy;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt[N];
    logic m_busy;

    always #5 clk = ~clk;

    cascaded_counter_chain dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .oneshot (oneshot),
        .ld      (ld),
        .ld_val  (ld_val),
        .term    (term),
        .count_o (count_o),
        .wrap_o  (wrap_o),
        .done_o  (done_o),
        .busy_o  (busy_o)
    );

    cascaded_counter_chain #(.NUM_STAGES(1), .STAGE_W(1)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .en      (en_p),
        .oneshot (1'b0),
        .ld      (1'b0),
        .ld_val  (ldv_a),
        .term    (term_a),
        .count_o (cnt_a),
        .wrap_o  (wrap_a),
        .done_o  (done_a),
        .busy_o  (busy_a)
    );

    cascaded_counter_chain #(.NUM_STAGES(5), .STAGE_W(8)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .en      (en_p),
        .oneshot (1'b0),
        .ld      (1'b0),
        .ld_val  (ldv_b),
        .term    (term_b),
        .count_o (cnt_b),
        .wrap_o  (wrap_b),
        .done_o  (done_b),
        .busy_o  (busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Model the next state from the inputs now applied, queue it, clock, then compare.
    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        logic carry;
        int   t;
        e.wrap = '0;
        e.done = 1'b0;
        if (rst || clr) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_busy = 1'b1;
        end else if (ld) begin
            for (int i = 0; i < N; i++) m_cnt[i] = int'(ld_val[i*W +: W]);
            m_busy = 1'b1;
        end else begin
            carry = en && m_busy;
            for (int i = 0; i < N; i++) begin
                t = int'(term[i*W +: W]);
                if (carry) begin
                    if (m_cnt[i] >= t) begin
                        m_cnt[i]  = 0;
                        e.wrap[i] = 1'b1;
                    end else begin
                        m_cnt[i] = (m_cnt[i] + 1) % (1 << W);
                        carry    = 1'b0;
                    end
                end
            end
            e.done = e.wrap[N-1];
            if (e.done && oneshot) m_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) e.cnt[i*W +: W] = m_cnt[i][W-1:0];
        e.busy = m_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, ".count"}, 64'(count_o), 64'(got.cnt));
        check({tag, ".wrap"},  64'(wrap_o),  64'(got.wrap));
        check({tag, ".done"},  64'(done_o),  64'(got.done));
        check({tag, ".busy"},  64'(busy_o),  64'(got.busy));
    endtask

    initial begin
        int n_w0, n_w1, n_done, done_at;
        int a_first, a_cnt, b_first, b_second;

        rst = 1'b1; clr = 1'b0; en = 1'b0; oneshot = 1'b0; ld = 1'b0;
        ld_val = '0; term = 12'h333;
        en_p = 1'b0; term_a = 1'b1; ldv_a = '0; ldv_b = '0;
        term_b = {8'd1, 8'd3, 8'd0, 8'd2, 8'd1};

        tick("reset");
        check("reset.count0", 64'(count_o), 64'(0));
        check("reset.busy1", 64'(busy_o), 64'(1));
        rst = 1'b0;

        // 1: free-run 64 cycles
        en = 1'b1; n_w0 = 0; n_w1 = 0; n_done = 0; done_at = 0;
        for (int c = 1; c <= 64; c++) begin
            tick("freerun");
            if (wrap_o[0]) n_w0++;
            if (wrap_o[1]) n_w1++;
            if (done_o) begin n_done++; done_at = c; end
        end
        check("freerun.wrap0_count", 64'(n_w0), 64'(16));
        check("freerun.wrap1_count", 64'(n_w1), 64'(4));
        check("freerun.done_count", 64'(n_done), 64'(1));
        check("freerun.done_cycle", 64'(done_at), 64'(64));

        // 2: one-shot with term 1,1,1
        oneshot = 1'b1; term = 12'h111; n_done = 0; done_at = 0;
        for (int c = 1; c <= 28; c++) begin
            tick("oneshot");
            if (done_o) begin n_done++; done_at = c; end
        end
        check("oneshot.done_count", 64'(n_done), 64'(1));
        check("oneshot.done_cycle", 64'(done_at), 64'(8));
        check("oneshot.halted", 64'(busy_o), 64'(0));
        oneshot = 1'b0;
        tick("oneshot_off_no_rearm");
        check("oneshot.still_halted", 64'(busy_o), 64'(0));
        ld = 1'b1; en = 1'b0; ld_val = '0;
        tick("oneshot_rearm");
        check("oneshot.rearm_busy", 64'(busy_o), 64'(1));

        // 3: over-terminal load
        term = 12'h335; ld_val = 12'h009;
        tick("load");
        ld = 1'b0; en = 1'b1;
        tick("load_step");
        check("load.count", 64'(count_o), 64'(12'h010));
        check("load.wrap", 64'(wrap_o), 64'(3'b001));
        en = 1'b0;

        // 4: divide-by-1 stage 0
        clr = 1'b1;
        tick("clr");
        clr = 1'b0; term = 12'h220; en = 1'b1;
        tick("div1_a");
        tick("div1_b");
        check("div1.count", 64'(count_o), 64'(12'h020));
        for (int c = 0; c < 6; c++) begin
            tick("div1");
            check("div1.wrap0", 64'(wrap_o[0]), 64'(1));
        end

        // 5: clr and ld together mid-count
        term = 12'h333;
        tick("pre_clrld_a");
        tick("pre_clrld_b");
        clr = 1'b1; ld = 1'b1; ld_val = 12'h555;
        tick("clr_ld");
        check("clr_ld.count", 64'(count_o), 64'(0));
        clr = 1'b0; ld = 1'b0;

        // 6: rst on a step that would raise done
        term = 12'h000;
        tick("done_every_step");
        check("term0.done", 64'(done_o), 64'(1));
        rst = 1'b1;
        tick("rst_abort");
        check("rst_abort.done", 64'(done_o), 64'(0));

        // 7: parameter sweep, done period = product(term_i+1)
        en = 1'b0;
        tick("sweep_reset");
        rst = 1'b0;
        en_p = 1'b1; a_first = 0; a_cnt = 0; b_first = 0; b_second = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                a_cnt++;
                if (a_first == 0) a_first = c;
            end
            if (done_b) begin
                if (b_first == 0) b_first = c;
                else if (b_second == 0) b_second = c;
            end
        end
        check("sweep.a_first", 64'(a_first), 64'(2));
        check("sweep.a_count", 64'(a_cnt), 64'(50));
        check("sweep.b_first", 64'(b_first), 64'(48));
        check("sweep.b_second", 64'(b_second), 64'(96));
        check("sweep.busy", 64'({busy_a, busy_b}), 64'(2'b11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
